// File: rtl/tbus_store_responder_pkg.sv
// Shared definitions for the tbus store responder: op encodings, FSM state enum.
package tbus_store_responder_pkg;

  localparam int TBUS_OPTYPE_W = 2;
  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_READ  = 2'd0;
  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_WRITE = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_DONE    = 3'd4
  } tbus_resp_state_e;

endpackage

// File: rtl/tbus_store_responder_if.sv
// tbus request port plus backing-memory handshake; slave = responder, master = requester/memory.
interface tbus_store_responder_if #(
  parameter int MEM_AW = 32
);
  import tbus_store_responder_pkg::*;

  logic                     tbus_index_valid;
  logic                     tbus_index_ready;
  logic [63:0]              tbus_index;
  logic [63:0]              tbus_write_data;
  logic [63:0]              tbus_write_mask;
  logic [TBUS_OPTYPE_W-1:0] tbus_operation_type;
  logic [63:0]              tbus_read_data;
  logic                     tbus_operation_done;

  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_we;
  logic [MEM_AW-1:0]        mem_addr;
  logic [63:0]              mem_wdata;
  logic                     mem_resp_valid;
  logic [63:0]              mem_resp_data;

  modport slave (
    input  tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type,
    output tbus_index_ready, tbus_read_data, tbus_operation_done,
    output mem_req_valid, mem_we, mem_addr, mem_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type,
    input  tbus_index_ready, tbus_read_data, tbus_operation_done,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );

endinterface

// File: rtl/tbus_store_responder_mask_merge.sv
// Bit-granular merge of old memory data with store data under a write mask.
module tbus_mask_merge (
  input  logic [63:0] old_data,
  input  logic [63:0] write_data,
  input  logic [63:0] write_mask,
  output logic [63:0] merged
);

  assign merged = (old_data & ~write_mask) | (write_data & write_mask);

endmodule

// File: rtl/tbus_store_responder.sv
// tbus memory-side responder: one request at a time, reads and RMW masked writes.
// Optional: TBUS_RESP_FULLMASK_BYPASS_EN skips the read for all-ones-mask writes.
module tbus_store_responder
  import tbus_store_responder_pkg::*;
#(
  parameter int ADDR_LSB = 3,
  parameter int MEM_AW   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  tbus_store_responder_if.slave bus
);

  localparam logic [2:0] IDLE    = S_IDLE;
  localparam logic [2:0] RD_REQ  = S_RD_REQ;
  localparam logic [2:0] RD_WAIT = S_RD_WAIT;
  localparam logic [2:0] WR_REQ  = S_WR_REQ;
  localparam logic [2:0] DONE    = S_DONE;

  logic [2:0]               state_q;
  logic [63:0]              idx_q, data_q, mask_q;
  logic [TBUS_OPTYPE_W-1:0] op_q;
  // Holds the read response for reads, the word to store for writes.
  logic [63:0]              buf_q;
  logic [63:0]              merged;
  logic                     full_mask_bypass;

  tbus_mask_merge u_merge (
    .old_data   (bus.mem_resp_data),
    .write_data (data_q),
    .write_mask (mask_q),
    .merged     (merged)
  );

`ifdef TBUS_RESP_FULLMASK_BYPASS_EN
  assign full_mask_bypass = (bus.tbus_write_mask == '1);
`else
  assign full_mask_bypass = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      op_q    <= '0;
      buf_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.tbus_index_valid) begin
          idx_q  <= bus.tbus_index;
          data_q <= bus.tbus_write_data;
          mask_q <= bus.tbus_write_mask;
          op_q   <= bus.tbus_operation_type;
          case (bus.tbus_operation_type)
            TBUS_READ:  state_q <= RD_REQ;
            TBUS_WRITE: begin
              if (full_mask_bypass) begin
                buf_q   <= bus.tbus_write_data;
                state_q <= WR_REQ;
              end else begin
                state_q <= RD_REQ;
              end
            end
            default: begin
              buf_q   <= '0;
              state_q <= DONE;
            end
          endcase
        end
        RD_REQ: if (bus.mem_req_ready) state_q <= RD_WAIT;
        RD_WAIT: if (bus.mem_resp_valid) begin
          if (op_q == TBUS_WRITE) begin
            buf_q   <= merged;
            state_q <= WR_REQ;
          end else begin
            buf_q   <= bus.mem_resp_data;
            state_q <= DONE;
          end
        end
        WR_REQ: if (bus.mem_req_ready) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tbus_index_ready    = (state_q == IDLE);
  assign bus.tbus_operation_done = (state_q == DONE);
  assign bus.tbus_read_data      = (state_q == DONE && op_q == TBUS_READ) ? buf_q : '0;
  assign bus.mem_req_valid       = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign bus.mem_we              = (state_q == WR_REQ);
  assign bus.mem_addr            = idx_q[ADDR_LSB +: MEM_AW];
  assign bus.mem_wdata           = buf_q;

endmodule

// File: tb/tb_tbus_store_responder.sv
// Directed bench for tbus_store_responder with a transaction-level model and per-cycle compare.
module tb_tbus_store_responder;
  import tbus_store_responder_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tbus_store_responder_if #(.MEM_AW(32)) bus ();

  tbus_store_responder #(.ADDR_LSB(3), .MEM_AW(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Model: expected memory image and outstanding transaction (at most one).
  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [63:0] exp_rdata;
    logic [63:0] exp_wdata;
  } txn_t;
  txn_t        q[$];
  logic [63:0] emem[logic [31:0]];
  logic [63:0] bmem[logic [31:0]];

  function automatic void model_accept(logic [1:0] op, logic [63:0] idx, logic [63:0] wd, logic [63:0] mask);
    txn_t t;
    logic [63:0] old;
    t.op   = op;
    t.addr = 32'(idx >> 3);
    old    = emem.exists(t.addr) ? emem[t.addr] : 64'h0;
    t.exp_rdata = (op == TBUS_READ) ? old : 64'h0;
    t.exp_wdata = (old & ~mask) | (wd & mask);
    if (op == TBUS_WRITE) emem[t.addr] = t.exp_wdata;
    q.push_back(t);
  endfunction

  // Memory model: configurable request-ready and response delays.
  int cfg_rdy = 0, cfg_rs = 0, rdy_cnt = 0, rs_cnt = 0;
  bit rs_pend = 0;
  logic [31:0] rs_addr, last_addr;
  logic [63:0] last_wdata;
  int n_rd = 0, n_wr = 0, n_done = 0;

  initial begin
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '1;
    forever begin
      @(negedge clock);
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '1;
      if (rs_pend) begin
        if (rs_cnt == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = bmem.exists(rs_addr) ? bmem[rs_addr] : 64'h0;
          rs_pend = 0;
        end else rs_cnt--;
      end
      if (bus.mem_req_valid && !reset) begin
        if (rdy_cnt > 0) rdy_cnt--;
        else begin
          bus.mem_req_ready = 1'b1;
          rdy_cnt   = cfg_rdy;
          last_addr = bus.mem_addr;
          if (bus.mem_we) begin
            bmem[bus.mem_addr] = bus.mem_wdata;
            last_wdata = bus.mem_wdata;
            n_wr++;
          end else begin
            rs_pend = 1; rs_cnt = cfg_rs; rs_addr = bus.mem_addr;
            n_rd++;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(posedge clock); #2;
      if (reset) begin
        chk("rst_ready", bus.tbus_index_ready, 1);
        chk("rst_done", bus.tbus_operation_done, 0);
        chk("rst_mem_req_valid", bus.mem_req_valid, 0);
        q.delete();
      end else begin
        chk("index_ready", bus.tbus_index_ready, q.size() == 0);
        if (bus.mem_req_valid) begin
          if (q.size() == 0 || q[0].op > TBUS_WRITE) chk("mem_req_unexpected", 1, 0);
          else begin
            chk("mem_addr", bus.mem_addr, q[0].addr);
            if (q[0].op == TBUS_READ) chk("mem_we_on_read", bus.mem_we, 0);
            else if (bus.mem_we) chk("mem_wdata", bus.mem_wdata, q[0].exp_wdata);
          end
        end
        if (bus.tbus_operation_done) begin
          n_done++;
          if (q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            chk("read_data", bus.tbus_read_data, q[0].exp_rdata);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  // Requester: caller sits at a negedge; returns cycles waited for ready and latency to done.
  task automatic req(input logic [1:0] op, input logic [63:0] idx, input logic [63:0] wd,
                     input logic [63:0] mask, input bit hold,
                     output int wcyc, output int lat, output logic [63:0] rd);
    bus.tbus_index_valid    = 1'b1;
    bus.tbus_operation_type = op;
    bus.tbus_index          = idx;
    bus.tbus_write_data     = wd;
    bus.tbus_write_mask     = mask;
    wcyc = 0;
    while (!bus.tbus_index_ready && wcyc < 50) begin @(negedge clock); wcyc++; end
    if (wcyc >= 50) chk("accept_timeout", 1, 0);
    model_accept(op, idx, wd, mask);
    lat = 0;
    rd  = '0;
    do begin @(negedge clock); lat++; end while (!bus.tbus_operation_done && lat < 60);
    if (lat >= 60) chk("done_timeout", 1, 0);
    rd = bus.tbus_read_data;
    if (!hold) bus.tbus_index_valid = 1'b0;
  endtask

  int w, lat, r0, w0;
  logic [63:0] rd;

  initial begin
    bus.tbus_index_valid    = 1'b0;
    bus.tbus_index          = '0;
    bus.tbus_write_data     = '0;
    bus.tbus_write_mask     = '0;
    bus.tbus_operation_type = TBUS_READ;
    repeat (3) @(negedge clock);
    chk("reset_ready", bus.tbus_index_ready, 1);
    chk("reset_done", bus.tbus_operation_done, 0);
    chk("reset_read_data", bus.tbus_read_data, 0);
    chk("reset_mem_req_valid", bus.mem_req_valid, 0);
    chk("reset_mem_we", bus.mem_we, 0);
    chk("reset_mem_addr", bus.mem_addr, 0);
    chk("reset_mem_wdata", bus.mem_wdata, 0);
    bmem[32'h10] = 64'h1122334455667788;
    emem[32'h10] = 64'h1122334455667788;
    reset = 1'b0;
    @(negedge clock);

    // Plain read
    req(TBUS_READ, 64'h80, 0, 0, 0, w, lat, rd);
    chk("read_latency", lat, 3);
    chk("read_mem_addr", last_addr, 32'h10);
    chk("read_data_lit", rd, 64'h1122334455667788);

    // Byte RMW write
    @(negedge clock);
    req(TBUS_WRITE, 64'h80, 64'hAB, 64'hFF, 0, w, lat, rd);
    chk("rmw_latency", lat, 4);
    chk("rmw_wdata_lit", last_wdata, 64'h11223344556677AB);
    chk("rmw_mem", bmem[32'h10], 64'h11223344556677AB);

    // Full-mask write
    @(negedge clock);
    r0 = n_rd;
    req(TBUS_WRITE, 64'h80, 64'hDEADBEEFCAFEF00D, '1, 0, w, lat, rd);
`ifdef TBUS_RESP_FULLMASK_BYPASS_EN
    chk("full_latency", lat, 2);
    chk("full_reads", n_rd - r0, 0);
`else
    chk("full_latency", lat, 4);
    chk("full_reads", n_rd - r0, 1);
`endif
    chk("full_mem", bmem[32'h10], 64'hDEADBEEFCAFEF00D);

    // Unknown op: immediate done, no memory traffic
    @(negedge clock);
    r0 = n_rd; w0 = n_wr;
    req(2'd2, 64'h88, 64'h55, '1, 0, w, lat, rd);
    chk("other_latency", lat, 1);
    chk("other_rdata", rd, 0);
    chk("other_traffic", (n_rd - r0) + (n_wr - w0), 0);

    // Slow memory: ready held off 5 cycles, response delayed 7
    @(negedge clock);
    cfg_rdy = 5; cfg_rs = 7; rdy_cnt = 5;
    req(TBUS_READ, 64'h80, 0, 0, 0, w, lat, rd);
    chk("slow_read_latency", lat, 15);
    chk("slow_read_data", rd, 64'hDEADBEEFCAFEF00D);
    @(negedge clock);
    req(TBUS_WRITE, 64'h100, 64'h0000_0000_1234_5678, 64'h0000_0000_FFFF_0000, 0, w, lat, rd);
    chk("slow_rmw_latency", lat, 21);
    chk("slow_rmw_mem", bmem[32'h20], 64'h0000_0000_1234_0000);
    cfg_rdy = 0; cfg_rs = 0; rdy_cnt = 0;

    // Reset during RD_WAIT with a late response
    @(negedge clock);
    cfg_rs = 4;
    r0 = n_rd; w0 = n_done;
    bus.tbus_index_valid = 1'b1; bus.tbus_operation_type = TBUS_READ; bus.tbus_index = 64'h80;
    model_accept(TBUS_READ, 64'h80, 0, 0);
    for (int i = 0; i < 20 && n_rd == r0; i++) begin @(negedge clock); #1; end
    chk("rst_test_read_issued", n_rd - r0, 1);
    @(negedge clock);
    reset = 1'b1; bus.tbus_index_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0; cfg_rs = 0;
    repeat (8) @(negedge clock);
    chk("rst_no_done", n_done - w0, 0);
    chk("rst_idle_ready", bus.tbus_index_ready, 1);
    req(TBUS_READ, 64'h80, 0, 0, 0, w, lat, rd);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_data", rd, 64'hDEADBEEFCAFEF00D);

    // Back-to-back reads, valid held
    @(negedge clock);
    req(TBUS_READ, 64'h80, 0, 0, 1, w, lat, rd);
    chk("b2b_first_data", rd, 64'hDEADBEEFCAFEF00D);
    req(TBUS_READ, 64'h100, 0, 0, 0, w, lat, rd);
    chk("b2b_accept_gap", w, 1);
    chk("b2b_second_data", rd, 64'h0000_0000_1234_0000);

    repeat (3) @(negedge clock);
    chk("final_mem_10", bmem[32'h10], emem[32'h10]);
    chk("final_mem_20", bmem[32'h20], emem[32'h20]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
